// File: rtl/overlay_mixer_if.sv
// rtl/overlay_mixer_if.sv - pixel-in / pixel-out bundle for the overlay mixer
//
// Purpose: groups the source pixel stream, mode/move controls and the mixed
//          output stream so the mixer and its driver share one port.
// Signals:
//   iDVAL, iX_Cont, iY_Cont, iRed/iGreen/iBlue  source pixel and its position
//   iMODE                                       requested overlay mode
//   iMOVE_L/R/U/D                               one-cycle window move pulses
//   oDVAL, oX_Cont, oY_Cont, oRed/oGreen/oBlue  mixed pixel, two cycles later
// Modports: master drives the source side, slave is the mixer.

interface overlay_mixer_if #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 11
);
    logic              iDVAL;
    logic [CNT_W-1:0]  iX_Cont;
    logic [CNT_W-1:0]  iY_Cont;
    logic [DATA_W-1:0] iRed;
    logic [DATA_W-1:0] iGreen;
    logic [DATA_W-1:0] iBlue;
    logic [1:0]        iMODE;
    logic              iMOVE_L;
    logic              iMOVE_R;
    logic              iMOVE_U;
    logic              iMOVE_D;
    logic              oDVAL;
    logic [CNT_W-1:0]  oX_Cont;
    logic [CNT_W-1:0]  oY_Cont;
    logic [DATA_W-1:0] oRed;
    logic [DATA_W-1:0] oGreen;
    logic [DATA_W-1:0] oBlue;

    modport master (
        output iDVAL, iX_Cont, iY_Cont, iRed, iGreen, iBlue,
        output iMODE, iMOVE_L, iMOVE_R, iMOVE_U, iMOVE_D,
        input  oDVAL, oX_Cont, oY_Cont, oRed, oGreen, oBlue
    );

    modport slave (
        input  iDVAL, iX_Cont, iY_Cont, iRed, iGreen, iBlue,
        input  iMODE, iMOVE_L, iMOVE_R, iMOVE_U, iMOVE_D,
        output oDVAL, oX_Cont, oY_Cont, oRed, oGreen, oBlue
    );
endinterface

// File: rtl/overlay_mixer.sv
// rtl/overlay_mixer.sv - registered RGB overlay: two vertical bars plus a movable centre window
//
// Purpose: two-stage pixel pipeline that paints bars at both screen edges and
//          shows a centre window as passthrough, grey or inverted content.
//          Window position and mode are only updated on the first pixel of a
//          frame so the picture never tears.
// Ports:
//   iCLK    pixel clock, all state updates on its falling edge
//   iRST_N  synchronous active-low reset
//   bus     overlay_mixer_if.slave: source pixel, mode, move pulses, mixed pixel
// Optional feature: define OVL_BLINK_EN to add a frame counter that blinks the
//   window border in BAR_COLOR while the counter MSB is set.

module overlay_mixer #(
    parameter int DATA_W    = 12,
    parameter int CNT_W     = 11,
    parameter int H_ACT     = 800,
    parameter int V_ACT     = 480,
    parameter int BAR_LO    = 10,
    parameter int BAR_HI    = 20,
    parameter int BAR_COLOR = 200,
    parameter int WIN_HALF  = 50,
    parameter int STEP      = 8,
    parameter int BLINK_W   = 5
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    overlay_mixer_if.slave  bus
);

    localparam logic [CNT_W-1:0]  CX_RST  = CNT_W'(H_ACT / 2);
    localparam logic [CNT_W-1:0]  CY_RST  = CNT_W'(V_ACT / 2);
    localparam logic [CNT_W:0]    CX_MIN  = (CNT_W+1)'(WIN_HALF);
    localparam logic [CNT_W:0]    CX_MAX  = (CNT_W+1)'(H_ACT - 1 - WIN_HALF);
    localparam logic [CNT_W:0]    CY_MIN  = (CNT_W+1)'(WIN_HALF);
    localparam logic [CNT_W:0]    CY_MAX  = (CNT_W+1)'(V_ACT - 1 - WIN_HALF);
    localparam logic [CNT_W:0]    STEP_W  = (CNT_W+1)'(STEP);
    localparam logic [CNT_W-1:0]  L_LO    = CNT_W'(BAR_LO);
    localparam logic [CNT_W-1:0]  L_HI    = CNT_W'(BAR_HI);
    localparam logic [CNT_W-1:0]  R_LO    = CNT_W'(H_ACT - 1 - BAR_HI);
    localparam logic [CNT_W-1:0]  R_HI    = CNT_W'(H_ACT - 1 - BAR_LO);
    localparam logic [CNT_W-1:0]  HALF    = CNT_W'(WIN_HALF);
    localparam logic [CNT_W-1:0]  EDGE    = CNT_W'(WIN_HALF - 1);
    localparam logic [DATA_W-1:0] BAR_VAL = DATA_W'(BAR_COLOR);
    localparam logic [DATA_W-1:0] FULL    = {DATA_W{1'b1}};

    // Frame-boundary control state
    logic [CNT_W-1:0] cx, cy;
    logic [1:0]       mode_act;
    logic             pend_l, pend_r, pend_u, pend_d;
    logic             boundary;

    // Values in force for the current pixel (boundary pixel already sees the update)
    logic [CNT_W:0]   cx_step, cy_step;
    logic [CNT_W-1:0] cx_next, cy_next, cx_use, cy_use;
    logic [1:0]       mode_use;

    // Region decode
    logic [CNT_W-1:0]  dx, dy;
    logic              in_bar, in_win, on_edge, blink;
    logic [DATA_W+1:0] grey_sum;

    // Stage 1
    logic              s1_dval, s1_bar, s1_win, s1_edge;
    logic [CNT_W-1:0]  s1_x, s1_y;
    logic [DATA_W-1:0] s1_r, s1_g, s1_b, s1_grey;
    logic [1:0]        s1_mode;

    // Stage 2 select
    logic [DATA_W-1:0] mix_r, mix_g, mix_b;

    assign boundary = bus.iDVAL && (bus.iX_Cont == '0) && (bus.iY_Cont == '0);

    // Opposite pending moves cancel; the result is clamped so the window stays on screen.
    always_comb begin
        cx_step = {1'b0, cx};
        cy_step = {1'b0, cy};
        if (pend_l && !pend_r)      cx_step = {1'b0, cx} - STEP_W;
        else if (pend_r && !pend_l) cx_step = {1'b0, cx} + STEP_W;
        if (pend_u && !pend_d)      cy_step = {1'b0, cy} - STEP_W;
        else if (pend_d && !pend_u) cy_step = {1'b0, cy} + STEP_W;

        cx_next = cx_step[CNT_W-1:0];
        if (cx_step < CX_MIN)      cx_next = CX_MIN[CNT_W-1:0];
        else if (cx_step > CX_MAX) cx_next = CX_MAX[CNT_W-1:0];
        cy_next = cy_step[CNT_W-1:0];
        if (cy_step < CY_MIN)      cy_next = CY_MIN[CNT_W-1:0];
        else if (cy_step > CY_MAX) cy_next = CY_MAX[CNT_W-1:0];

        cx_use   = boundary ? cx_next : cx;
        cy_use   = boundary ? cy_next : cy;
        mode_use = boundary ? bus.iMODE : mode_act;
    end

    // A pulse arriving on the boundary cycle is kept for the next frame rather than lost.
    always_ff @(negedge iCLK) begin
        if (!iRST_N) begin
            cx       <= CX_RST;
            cy       <= CY_RST;
            mode_act <= 2'd2;
            pend_l   <= 1'b0;
            pend_r   <= 1'b0;
            pend_u   <= 1'b0;
            pend_d   <= 1'b0;
        end else if (boundary) begin
            cx       <= cx_next;
            cy       <= cy_next;
            mode_act <= bus.iMODE;
            pend_l   <= bus.iMOVE_L;
            pend_r   <= bus.iMOVE_R;
            pend_u   <= bus.iMOVE_U;
            pend_d   <= bus.iMOVE_D;
        end else begin
            pend_l   <= pend_l | bus.iMOVE_L;
            pend_r   <= pend_r | bus.iMOVE_R;
            pend_u   <= pend_u | bus.iMOVE_U;
            pend_d   <= pend_d | bus.iMOVE_D;
        end
    end

`ifdef OVL_BLINK_EN
    logic [BLINK_W-1:0] frame_cnt, frame_cnt_use;

    always_ff @(negedge iCLK) begin
        if (!iRST_N)       frame_cnt <= '0;
        else if (boundary) frame_cnt <= frame_cnt + 1'b1;
    end

    assign frame_cnt_use = boundary ? frame_cnt + 1'b1 : frame_cnt;
`else
    logic [BLINK_W-1:0] frame_cnt_use;

    assign frame_cnt_use = '0;
`endif

    assign blink = frame_cnt_use[BLINK_W-1];

    always_comb begin
        dx = (bus.iX_Cont >= cx_use) ? bus.iX_Cont - cx_use : cx_use - bus.iX_Cont;
        dy = (bus.iY_Cont >= cy_use) ? bus.iY_Cont - cy_use : cy_use - bus.iY_Cont;
        in_bar  = ((bus.iX_Cont > L_LO) && (bus.iX_Cont < L_HI)) ||
                  ((bus.iX_Cont > R_LO) && (bus.iX_Cont < R_HI));
        in_win  = (dx < HALF) && (dy < HALF);
        on_edge = in_win && ((dx == EDGE) || (dy == EDGE));
        // Luma approximation weighting green twice; two guard bits hold the sum of four channels.
        grey_sum = {2'b00, bus.iRed} + {1'b0, bus.iGreen, 1'b0} + {2'b00, bus.iBlue};
    end

    always_ff @(negedge iCLK) begin
        if (!iRST_N) begin
            s1_dval <= 1'b0;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_r    <= '0;
            s1_g    <= '0;
            s1_b    <= '0;
            s1_grey <= '0;
            s1_bar  <= 1'b0;
            s1_win  <= 1'b0;
            s1_edge <= 1'b0;
            s1_mode <= 2'd0;
        end else begin
            s1_dval <= bus.iDVAL;
            s1_x    <= bus.iX_Cont;
            s1_y    <= bus.iY_Cont;
            s1_r    <= bus.iRed;
            s1_g    <= bus.iGreen;
            s1_b    <= bus.iBlue;
            s1_grey <= DATA_W'(grey_sum >> 2);
            s1_bar  <= in_bar;
            s1_win  <= in_win;
            s1_edge <= on_edge && blink && mode_use[1];
            s1_mode <= mode_use;
        end
    end

    always_comb begin
        mix_r = s1_r;
        mix_g = s1_g;
        mix_b = s1_b;
        if (s1_mode != 2'd0) begin
            if (s1_bar || s1_edge) begin
                mix_r = BAR_VAL;
                mix_g = BAR_VAL;
                mix_b = BAR_VAL;
            end else if (s1_win && s1_mode == 2'd2) begin
                mix_r = s1_grey;
                mix_g = s1_grey;
                mix_b = s1_grey;
            end else if (s1_win && s1_mode == 2'd3) begin
                mix_r = FULL - s1_r;
                mix_g = FULL - s1_g;
                mix_b = FULL - s1_b;
            end
        end
        if (!s1_dval) begin
            mix_r = '0;
            mix_g = '0;
            mix_b = '0;
        end
    end

    always_ff @(negedge iCLK) begin
        if (!iRST_N) begin
            bus.oDVAL   <= 1'b0;
            bus.oX_Cont <= '0;
            bus.oY_Cont <= '0;
            bus.oRed    <= '0;
            bus.oGreen  <= '0;
            bus.oBlue   <= '0;
        end else begin
            bus.oDVAL   <= s1_dval;
            bus.oX_Cont <= s1_x;
            bus.oY_Cont <= s1_y;
            bus.oRed    <= mix_r;
            bus.oGreen  <= mix_g;
            bus.oBlue   <= mix_b;
        end
    end

endmodule

// File: tb/tb_overlay_mixer.sv
// tb/tb_overlay_mixer.sv - directed vector bench for overlay_mixer

module tb_overlay_mixer;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    overlay_mixer_if bus ();

    overlay_mixer dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit bnd;
        int mode;
        bit dval;
        int x, y, r, g, b;
        int er, eg, eb;
        bit edv;
    } vec_t;

    vec_t vecs[25];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_px(input string name, input int er, input int eg, input int eb);
        chk({name, ".r"}, int'(bus.oRed), er);
        chk({name, ".g"}, int'(bus.oGreen), eg);
        chk({name, ".b"}, int'(bus.oBlue), eb);
    endtask

    // Presents one pixel for one cycle, idles, and returns when its result is on the outputs.
    task automatic send(input bit dv, input int x, input int y,
                        input int r, input int g, input int b, input bit [3:0] mv);
        @(posedge clk);
        bus.iDVAL   = dv;
        bus.iX_Cont = 11'(x);
        bus.iY_Cont = 11'(y);
        bus.iRed    = 12'(r);
        bus.iGreen  = 12'(g);
        bus.iBlue   = 12'(b);
        {bus.iMOVE_L, bus.iMOVE_R, bus.iMOVE_U, bus.iMOVE_D} = mv;
        @(posedge clk);
        bus.iDVAL = 1'b0;
        {bus.iMOVE_L, bus.iMOVE_R, bus.iMOVE_U, bus.iMOVE_D} = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start(input int mode);
        bus.iMODE = 2'(mode);
        send(1'b1, 0, 0, 0, 0, 0, 4'b0000);
    endtask

    task automatic pulse(input bit [3:0] mv);
        @(posedge clk);
        {bus.iMOVE_L, bus.iMOVE_R, bus.iMOVE_U, bus.iMOVE_D} = mv;
        @(posedge clk);
        {bus.iMOVE_L, bus.iMOVE_R, bus.iMOVE_U, bus.iMOVE_D} = 4'b0000;
    endtask

    // Grey window (mode 2): R=400,G=200,B=0 shows 200 inside and passes outside.
    task automatic check_cx(input int c, input int y);
        send(1'b1, c - 49, y, 400, 200, 0, 4'b0000);
        expect_px($sformatf("cx%0d_in_lo", c), 200, 200, 200);
        send(1'b1, c - 50, y, 400, 200, 0, 4'b0000);
        expect_px($sformatf("cx%0d_out_lo", c), 400, 200, 0);
        send(1'b1, c + 50, y, 400, 200, 0, 4'b0000);
        expect_px($sformatf("cx%0d_out_hi", c), 400, 200, 0);
    endtask

    task automatic check_cy(input int x, input int c);
        send(1'b1, x, c - 49, 400, 200, 0, 4'b0000);
        expect_px($sformatf("cy%0d_in", c), 200, 200, 200);
        send(1'b1, x, c - 50, 400, 200, 0, 4'b0000);
        expect_px($sformatf("cy%0d_out", c), 400, 200, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{1, 2, 1,  15, 100,  100, 100, 100,  200, 200, 200, 1};
        vecs[1]  = '{0, 2, 1, 785, 100,  100, 100, 100,  200, 200, 200, 1};
        vecs[2]  = '{0, 2, 1, 400, 240,  100, 100, 100,  100, 100, 100, 1};
        vecs[3]  = '{0, 2, 1,  10,   5,  100, 100, 100,  100, 100, 100, 1};
        vecs[4]  = '{0, 2, 1,  11,   5,  100, 100, 100,  200, 200, 200, 1};
        vecs[5]  = '{0, 2, 1,  20,   5,  100, 100, 100,  100, 100, 100, 1};
        vecs[6]  = '{0, 2, 1,  19,   5,  100, 100, 100,  200, 200, 200, 1};
        vecs[7]  = '{0, 2, 1, 779,   5,  100, 100, 100,  100, 100, 100, 1};
        vecs[8]  = '{0, 2, 1, 780,   5,  100, 100, 100,  200, 200, 200, 1};
        vecs[9]  = '{0, 2, 1, 789,   5,  100, 100, 100,  100, 100, 100, 1};
        vecs[10] = '{0, 2, 1, 400, 240,  400, 200,   0,  200, 200, 200, 1};
        vecs[11] = '{0, 2, 1, 460, 240,  400, 200,   0,  400, 200,   0, 1};
        vecs[12] = '{0, 2, 1, 449, 240,  400, 200,   0,  200, 200, 200, 1};
        vecs[13] = '{0, 2, 1, 450, 240,  400, 200,   0,  400, 200,   0, 1};
        vecs[14] = '{0, 2, 1, 351, 240,  400, 200,   0,  200, 200, 200, 1};
        vecs[15] = '{0, 2, 1, 400, 191,  400, 200,   0,  200, 200, 200, 1};
        vecs[16] = '{0, 2, 1, 400, 190,  400, 200,   0,  400, 200,   0, 1};
        vecs[17] = '{0, 2, 0,  15, 100,  100, 100, 100,    0,   0,   0, 0};
        vecs[18] = '{1, 3, 1, 400, 240, 4095,   0, 100,    0,4095,3995, 1};
        vecs[19] = '{0, 3, 1,  15,   5, 4095,   0, 100,  200, 200, 200, 1};
        vecs[20] = '{0, 3, 1, 500, 240, 4095,   0, 100, 4095,   0, 100, 1};
        vecs[21] = '{1, 1, 1, 400, 240, 4095,   0, 100, 4095,   0, 100, 1};
        vecs[22] = '{0, 1, 1,  15,   5, 4095,   0, 100,  200, 200, 200, 1};
        vecs[23] = '{1, 0, 1,  15,   5, 4095,   0, 100, 4095,   0, 100, 1};
        vecs[24] = '{1, 2, 1, 400, 240, 4095,   0, 100, 1048,1048,1048, 1};

        rst_n       = 1'b0;
        bus.iDVAL   = 1'b1;
        bus.iX_Cont = 11'd15;
        bus.iY_Cont = 11'd100;
        bus.iRed    = 12'd100;
        bus.iGreen  = 12'd100;
        bus.iBlue   = 12'd100;
        bus.iMODE   = 2'd2;
        {bus.iMOVE_L, bus.iMOVE_R, bus.iMOVE_U, bus.iMOVE_D} = 4'b0000;

        repeat (3) @(posedge clk);
        #1;
        expect_px("reset_rgb", 0, 0, 0);
        chk("reset_dval", int'(bus.oDVAL), 0);
        chk("reset_x", int'(bus.oX_Cont), 0);
        @(posedge clk);
        bus.iDVAL = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            if (vecs[i].bnd) frame_start(vecs[i].mode);
            send(vecs[i].dval, vecs[i].x, vecs[i].y, vecs[i].r, vecs[i].g, vecs[i].b, 4'b0000);
            expect_px($sformatf("vec%0d", i), vecs[i].er, vecs[i].eg, vecs[i].eb);
            chk($sformatf("vec%0d.dval", i), int'(bus.oDVAL), int'(vecs[i].edv));
            chk($sformatf("vec%0d.x", i), int'(bus.oX_Cont), vecs[i].x);
            chk($sformatf("vec%0d.y", i), int'(bus.oY_Cont), vecs[i].y);
        end

        // oDVAL follows iDVAL by exactly two cycles
        @(posedge clk);
        bus.iDVAL = 1'b1;
        bus.iX_Cont = 11'd300;
        bus.iY_Cont = 11'd300;
        @(posedge clk);
        bus.iDVAL = 1'b0;
        #1;
        chk("lat_dval_c1", int'(bus.oDVAL), 0);
        @(posedge clk);
        #1;
        chk("lat_dval_c2", int'(bus.oDVAL), 1);
        @(posedge clk);
        #1;
        chk("lat_dval_c3", int'(bus.oDVAL), 0);

        // Mode request mid-frame waits for the next boundary
        frame_start(3);
        bus.iMODE = 2'd2;
        send(1'b1, 400, 240, 4095, 0, 100, 4'b0000);
        expect_px("mode_midframe", 0, 4095, 3995);
        frame_start(2);
        send(1'b1, 400, 240, 4095, 0, 100, 4'b0000);
        expect_px("mode_nextframe", 1048, 1048, 1048);

        // Opposite moves in one frame cancel
        pulse(4'b1000);
        pulse(4'b0100);
        frame_start(2);
        check_cx(400, 240);

        for (int i = 0; i < 10; i++) begin
            pulse(4'b1000);
            frame_start(2);
        end
        check_cx(320, 240);

        for (int i = 0; i < 50; i++) begin
            pulse(4'b1000);
            frame_start(2);
        end
        check_cx(50, 240);

        // Up request on the boundary cycle itself lands one frame later
        bus.iMODE = 2'd2;
        send(1'b1, 0, 0, 0, 0, 0, 4'b0010);
        check_cy(50, 240);
        frame_start(2);
        check_cy(50, 232);

        // Reset mid-frame clears the pipe and restores centre and mode
        frame_start(3);
        @(posedge clk);
        bus.iDVAL = 1'b1;
        bus.iX_Cont = 11'd50;
        bus.iY_Cont = 11'd232;
        bus.iRed = 12'd4095;
        bus.iGreen = 12'd0;
        bus.iBlue = 12'd100;
        @(posedge clk);
        bus.iDVAL = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        expect_px("midrst_rgb", 0, 0, 0);
        chk("midrst_dval", int'(bus.oDVAL), 0);
        rst_n = 1'b1;
        check_cx(400, 240);
        check_cy(400, 240);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
